// File: rtl/data_ram_resp.sv
// data_ram_resp: single-port data memory responder for the MEM stage, adding WAIT_STATES wait cycles per access.
// Optional feature macro DATA_RAM_ALIGN_CHECK_EN rejects irregular byte-lane patterns through err_o.
module data_ram_resp #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        ack_o,
  output logic        stall_o,
  output logic        err_o
);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  ack_q, ack_d;
  logic [31:0]           data_q, data_d;
  logic                  sel_bad;
  logic                  go_ack;
  logic                  wr_en;
  logic [DEPTH_LOG2-1:0] word_idx;
  logic [31:0]           mem [DEPTH];
  logic                  unused_addr;

  // Upper address bits alias and the byte offset never selects a word.
  assign word_idx    = addr_i[DEPTH_LOG2+1:2];
  assign unused_addr = ^{addr_i[31:DEPTH_LOG2+2], addr_i[1:0]};

`ifdef DATA_RAM_ALIGN_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    case (sel_i)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: sel_bad = 1'b0;
      4'b0000:                   sel_bad = ~we_i;
      default:                   sel_bad = 1'b1;
    endcase
  end

  assign err_d = go_ack & sel_bad;

  always_ff @(posedge clk) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= err_d;
  end

  assign err_o = err_q;
`else
  assign sel_bad = 1'b0;
  assign err_o   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    go_ack  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ce_i) begin
          cnt_d = 4'(WAIT_STATES);
          if (WAIT_STATES == 0) begin
            state_d = S_ACK;
            go_ack  = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!ce_i) begin
          state_d = S_IDLE;
        end else if (cnt_q <= 4'd1) begin
          state_d = S_ACK;
          go_ack  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Ack, read data and the commit all happen on the edge that enters ACK.
  always_comb begin
    ack_d  = go_ack;
    data_d = 32'h0;
    wr_en  = go_ack & we_i & ~sel_bad;
    if (go_ack && !we_i && !sel_bad) data_d = mem[word_idx];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      ack_q   <= 1'b0;
      data_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      data_q  <= data_d;
    end
  end

  // Array is never reset; a reset edge suppresses any pending commit.
  always_ff @(posedge clk) begin
    if (rst && wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (sel_i[i]) mem[word_idx][8*i +: 8] <= data_i[8*i +: 8];
      end
    end
  end

  assign data_o  = data_q;
  assign ack_o   = ack_q;
  assign stall_o = ce_i & ~ack_q;
endmodule

// File: tb/tb_data_ram_resp.sv
// Self-checking bench for data_ram_resp: instance 0 uses one wait state, instance 1 none.
// A cycle-counting transaction model is compared against both instances on every cycle.
module tb_data_ram_resp;
  localparam int W_A = 1;
  localparam int W_B = 0;

  logic        clk;
  logic        rst;
  logic [1:0]  ce;
  logic        we_s;
  logic [31:0] addr_s;
  logic [3:0]  sel_s;
  logic [31:0] wdata_s;
  logic [31:0] dout [2];
  logic [1:0]  ack;
  logic [1:0]  stall;
  logic [1:0]  err;

  int tests_run = 0;
  int tests_failed = 0;

  data_ram_resp #(.DEPTH_LOG2(10), .WAIT_STATES(W_A)) dut_a (
    .clk(clk), .rst(rst), .ce_i(ce[0]), .we_i(we_s), .addr_i(addr_s),
    .sel_i(sel_s), .data_i(wdata_s), .data_o(dout[0]), .ack_o(ack[0]),
    .stall_o(stall[0]), .err_o(err[0])
  );

  data_ram_resp #(.DEPTH_LOG2(10), .WAIT_STATES(W_B)) dut_b (
    .clk(clk), .rst(rst), .ce_i(ce[1]), .we_i(we_s), .addr_i(addr_s),
    .sel_i(sel_s), .data_i(wdata_s), .data_o(dout[1]), .ack_o(ack[1]),
    .stall_o(stall[1]), .err_o(err[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit sel_illegal(input bit we, input logic [3:0] sel);
`ifdef DATA_RAM_ALIGN_CHECK_EN
    if (sel == 4'b0000) return !we;
    return !(sel inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111});
`else
    return 1'b0;
`endif
  endfunction

  // Transaction model: an access completes once ce has been seen high on WAITS+1
  // consecutive edges; the edge after the ack is always spent returning to idle.
  logic [31:0] mmem [2][1024];
  int          held [2];
  bit          eack [2];
  bit          eerr [2];
  logic [31:0] edata [2];
  bit          started = 1'b0;

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int waits;
      int idx;
      waits = (d == 0) ? W_A : W_B;
      idx   = int'(addr_s[11:2]);
      if (!rst) begin
        held[d] = 0; eack[d] = 1'b0; eerr[d] = 1'b0; edata[d] = 32'h0;
      end else if (eack[d]) begin
        held[d] = 0; eack[d] = 1'b0; eerr[d] = 1'b0; edata[d] = 32'h0;
      end else if (ce[d]) begin
        held[d]++;
        if (held[d] == waits + 1) begin
          eack[d] = 1'b1;
          eerr[d] = sel_illegal(we_s, sel_s);
          if (!eerr[d]) begin
            if (we_s) begin
              for (int l = 0; l < 4; l++)
                if (sel_s[l]) mmem[d][idx][8*l +: 8] = wdata_s[8*l +: 8];
            end else begin
              edata[d] = mmem[d][idx];
            end
          end
        end
      end else begin
        held[d] = 0;
      end
    end
    if (!rst) started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      for (int d = 0; d < 2; d++) begin
        checkOutput($sformatf("ack%0d", d), {31'h0, ack[d]}, {31'h0, eack[d]});
        checkOutput($sformatf("err%0d", d), {31'h0, err[d]}, {31'h0, eerr[d]});
        checkOutput($sformatf("data%0d", d), dout[d], edata[d]);
        checkOutput($sformatf("stall%0d", d), {31'h0, stall[d]}, {31'h0, ce[d] & ~eack[d]});
      end
    end
  end

  task automatic applyStimulus(input int d, input bit we, input logic [31:0] addr,
                               input logic [3:0] sel, input logic [31:0] wd,
                               output logic [31:0] rd, output logic e, output int lat);
    bit got;
    we_s = we; addr_s = addr; sel_s = sel; wdata_s = wd;
    ce[d] = 1'b1;
    got = 1'b0; lat = 0; rd = 32'h0; e = 1'b0;
    while (!got && lat < 30) begin
      @(posedge clk); #1;
      lat++;
      if (ack[d]) begin
        got = 1'b1; rd = dout[d]; e = err[d];
      end
    end
    ce[d] = 1'b0;
    checkOutput("ack_seen", {31'h0, got}, 32'h1);
  endtask

  logic [31:0] rd;
  logic        e;
  int          lat;

  initial begin
    rst = 1'b0; ce = 2'b00; we_s = 1'b0; addr_s = 32'h0; sel_s = 4'h0; wdata_s = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    ce[0] = 1'b1;
    @(negedge clk);
    checkOutput("reset_ack", {31'h0, ack[0]}, 32'h0);
    checkOutput("reset_data", dout[0], 32'h0);
    checkOutput("reset_err", {31'h0, err[0]}, 32'h0);
    checkOutput("reset_stall", {31'h0, stall[0]}, 32'h1);
    @(posedge clk); #1;
    ce[0] = 1'b0;
    rst = 1'b1;

    applyStimulus(0, 1'b1, 32'h10, 4'b1111, 32'hDEADBEEF, rd, e, lat);
    checkOutput("store_latency", lat, 32'd2);
    applyStimulus(0, 1'b0, 32'h10, 4'b1111, 32'h0, rd, e, lat);
    checkOutput("load_deadbeef", rd, 32'hDEADBEEF);
    applyStimulus(0, 1'b1, 32'h10, 4'b0100, 32'h00AA0000, rd, e, lat);
    applyStimulus(0, 1'b0, 32'h10, 4'b1111, 32'h0, rd, e, lat);
    checkOutput("byte_store", rd, 32'hDEAABEEF);

    applyStimulus(0, 1'b1, 32'h1000, 4'b1111, 32'h12345678, rd, e, lat);
    applyStimulus(0, 1'b0, 32'h0000, 4'b1111, 32'h0, rd, e, lat);
    checkOutput("alias", rd, 32'h12345678);

    applyStimulus(0, 1'b1, 32'h20, 4'b1111, 32'h0BADF00D, rd, e, lat);
    we_s = 1'b1; addr_s = 32'h20; sel_s = 4'hF; wdata_s = 32'hFFFFFFFF;
    ce[0] = 1'b1;
    @(posedge clk); #1;
    ce[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    applyStimulus(0, 1'b0, 32'h20, 4'b1111, 32'h0, rd, e, lat);
    checkOutput("abort_no_write", rd, 32'h0BADF00D);

    we_s = 1'b1; addr_s = 32'h20; sel_s = 4'hF; wdata_s = 32'h55555555;
    ce[0] = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("rst_mid_ack", {31'h0, ack[0]}, 32'h0);
    checkOutput("rst_mid_data", dout[0], 32'h0);
    rst = 1'b1; ce[0] = 1'b0;
    applyStimulus(0, 1'b0, 32'h20, 4'b1111, 32'h0, rd, e, lat);
    checkOutput("rst_no_write", rd, 32'h0BADF00D);

    applyStimulus(0, 1'b1, 32'h30, 4'b1111, 32'h11223344, rd, e, lat);
    applyStimulus(0, 1'b1, 32'h30, 4'b0110, 32'hAABBCCDD, rd, e, lat);
`ifdef DATA_RAM_ALIGN_CHECK_EN
    checkOutput("misaligned_err", {31'h0, e}, 32'h1);
`else
    checkOutput("misaligned_err", {31'h0, e}, 32'h0);
`endif
    applyStimulus(0, 1'b0, 32'h30, 4'b1111, 32'h0, rd, e, lat);
`ifdef DATA_RAM_ALIGN_CHECK_EN
    checkOutput("misaligned_mem", rd, 32'h11223344);
`else
    checkOutput("misaligned_mem", rd, 32'h11BBCC44);
`endif
    applyStimulus(0, 1'b1, 32'h30, 4'b0000, 32'hFFFFFFFF, rd, e, lat);
    checkOutput("sel0_err", {31'h0, e}, 32'h0);
    applyStimulus(0, 1'b0, 32'h30, 4'b1111, 32'h0, rd, e, lat);
`ifdef DATA_RAM_ALIGN_CHECK_EN
    checkOutput("sel0_mem", rd, 32'h11223344);
`else
    checkOutput("sel0_mem", rd, 32'h11BBCC44);
`endif

    applyStimulus(1, 1'b1, 32'h100, 4'b1111, 32'hA5A5A5A5, rd, e, lat);
    checkOutput("b_store_latency", lat, 32'd1);
    applyStimulus(1, 1'b1, 32'h104, 4'b1111, 32'h5A5A5A5A, rd, e, lat);
    we_s = 1'b0; addr_s = 32'h100; sel_s = 4'hF;
    ce[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bit got;
      int gap;
      got = 1'b0; gap = 0;
      while (!got && gap < 10) begin
        @(posedge clk); #1;
        gap++;
        if (ack[1]) got = 1'b1;
      end
      checkOutput("b2b_ack", {31'h0, got}, 32'h1);
      checkOutput("b2b_data", dout[1], (k % 2 == 0) ? 32'hA5A5A5A5 : 32'h5A5A5A5A);
      if (k > 0) checkOutput("b2b_gap", gap, 32'd2);
      addr_s = (k % 2 == 0) ? 32'h104 : 32'h100;
    end
    ce[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
